// File: rtl/audio_pkg.sv
// Shared widths, FSM states and constants for the audio playback path.
package audio_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  localparam logic [15:0] SILENCE = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_TICK
  } state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate strobe: one-cycle tick every CLK_HZ/SAMPLE_HZ clocks.
module sample_tick_gen #(
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = 8000
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/sfx_player.sv
// Sound-effect playback engine: fetches PCM samples from memory and emits one
// per sample tick, handling one-shot, looped and aborted clips.
module sfx_player #(
  parameter int ADDR_W    = audio_pkg::ADDR_W,
  parameter int DATA_W    = audio_pkg::DATA_W,
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = 8000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              play,
  input  logic              loop,
  input  logic              Audio_Reset,
  input  logic [ADDR_W-1:0] Start_Addr,
  input  logic [ADDR_W-1:0] End_Addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  import audio_pkg::*;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_cur, r_sAddr, r_eAddr;
  logic [DATA_W-1:0] r_buf, r_sample;
  logic              r_lp, r_armed;
  logic              r_valid, r_done, r_underrun;

  logic w_tick, w_abort, w_start, w_last, w_finish;

  sample_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ)
  ) u_tick (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .tick   (w_tick)
  );

  assign w_abort  = Audio_Reset | (!play && (r_state != IDLE));
  assign w_start  = (r_state == IDLE) && play && !Audio_Reset && r_armed &&
                    (End_Addr >= Start_Addr);
  assign w_last   = (r_cur == r_eAddr);
  assign w_finish = (r_state == WAIT_TICK) && w_tick && !w_abort && w_last && !r_lp;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:      if (w_start) w_next = FETCH;
        FETCH:     if (mem_ack) w_next = WAIT_TICK;
        WAIT_TICK: if (w_tick)  w_next = w_finish ? IDLE : FETCH;
        default:   w_next = IDLE;
      endcase
    end
  end

  // armed drops together with done so a still-held play cannot restart the clip
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_armed <= 1'b1;
    end else if (!play || Audio_Reset) begin
      r_armed <= 1'b1;
    end else if (w_finish) begin
      r_armed <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cur      <= '0;
      r_sAddr    <= '0;
      r_eAddr    <= '0;
      r_lp       <= 1'b0;
      r_buf      <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      if (w_abort) begin
        r_sample <= DATA_W'(SILENCE);
      end else begin
        case (r_state)
          IDLE: begin
            r_sample <= DATA_W'(SILENCE);
            if (w_start) begin
              r_sAddr <= Start_Addr;
              r_eAddr <= End_Addr;
              r_lp    <= loop;
              r_cur   <= Start_Addr;
            end
          end
          FETCH: begin
            if (mem_ack) r_buf <= mem_rdata;
            if (w_tick)  r_underrun <= 1'b1;
          end
          WAIT_TICK: begin
            if (w_tick) begin
              r_sample <= r_buf;
              r_valid  <= 1'b1;
              if (!w_last) begin
                r_cur <= r_cur + ADDR_W'(1);
              end else if (r_lp) begin
                r_cur <= r_sAddr;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_rd       = (r_state == FETCH);
  assign mem_addr     = r_cur;
  assign busy         = (r_state != IDLE);
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign done         = r_done;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player: table of one-shot clips plus hand-written
// loop, abort and asynchronous-reset sequences against a simple memory model.
module tb_sfx_player;

  localparam int AW = 23;
  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          play = 1'b0;
  logic          loop = 1'b0;
  logic          Audio_Reset = 1'b0;
  logic [AW-1:0] Start_Addr = '0;
  logic [AW-1:0] End_Addr = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] sample_out;
  logic          sample_valid, busy, done, underrun;

  int checks = 0;
  int errors = 0;

  int memLatency = 2;
  int memCnt = 0;

  int doneCnt = 0, underrunCnt = 0, busyCnt = 0, rdCnt = 0, holdErr = 0;
  logic [DW-1:0] lastSample = '0;
  logic          prevRd = 1'b0;
  logic [DW-1:0] validQ[$];
  logic [AW-1:0] addrQ[$];

  typedef struct {
    logic [AW-1:0] startA;
    logic [AW-1:0] endA;
    int            latency;
    int            expCount;
    logic [DW-1:0] expFirst;
    int            expDone;
    bit            expUnderrun;
  } vec_t;

  vec_t vecs[4];

  sfx_player #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .CLK_HZ   (80),
    .SAMPLE_HZ(10)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .play        (play),
    .loop        (loop),
    .Audio_Reset (Audio_Reset),
    .Start_Addr  (Start_Addr),
    .End_Addr    (End_Addr),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  always #5 Clk = ~Clk;

  // memory model: one-cycle ack memLatency cycles after mem_rd rises, data = addr[15:0]
  always @(negedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mem_ack = 1'b0;
      memCnt  = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      memCnt  = 0;
    end else if (mem_rd) begin
      memCnt++;
      if (memCnt >= memLatency) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr[15:0];
      end
    end else begin
      memCnt = 0;
    end
  end

  always @(negedge Clk) begin
    if (sample_valid || !busy) lastSample = sample_out;
    if (sample_valid) validQ.push_back(sample_out);
    if (done) doneCnt++;
    if (underrun) begin
      underrunCnt++;
      if (sample_out !== lastSample) holdErr++;
    end
    if (busy) busyCnt++;
    if (mem_rd) rdCnt++;
    if (mem_rd && !prevRd) addrQ.push_back(mem_addr);
    prevRd = mem_rd;
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int qBase, doneBase, urBase, busyBase, rdBase, holdBase, rdAtDone;
    play = 1'b0;
    step();
    step();
    qBase    = validQ.size();
    doneBase = doneCnt;
    urBase   = underrunCnt;
    busyBase = busyCnt;
    rdBase   = rdCnt;
    holdBase = holdErr;
    rdAtDone = -1;
    memLatency = v.latency;
    Start_Addr = v.startA;
    End_Addr   = v.endA;
    loop       = 1'b0;
    play       = 1'b1;
    for (int c = 0; c < 800; c++) begin
      step();
      if (doneCnt > doneBase) begin
        rdAtDone = rdCnt;
        break;
      end
      if (v.expDone == 0 && c >= 40) break;
    end
    for (int c = 0; c < 40; c++) step();
    checkOutput($sformatf("v%0d_count", idx), validQ.size() - qBase, v.expCount);
    for (int k = 0; k < v.expCount; k++) begin
      checkOutput($sformatf("v%0d_sample%0d", idx, k),
                  (qBase + k < validQ.size()) ? longint'(validQ[qBase + k]) : -1,
                  longint'(v.expFirst) + k);
    end
    checkOutput($sformatf("v%0d_done", idx), doneCnt - doneBase, v.expDone);
    checkOutput($sformatf("v%0d_busy_end", idx), busy, 0);
    checkOutput($sformatf("v%0d_sample_end", idx), sample_out, 0);
    if (v.expDone != 0) begin
      checkOutput($sformatf("v%0d_rd_after_done", idx), (rdAtDone < 0) ? -1 : rdCnt - rdAtDone, 0);
    end else begin
      checkOutput($sformatf("v%0d_busy_cycles", idx), busyCnt - busyBase, 0);
      checkOutput($sformatf("v%0d_rd_cycles", idx), rdCnt - rdBase, 0);
    end
    if (v.expUnderrun) begin
      checkOutput($sformatf("v%0d_underrun_seen", idx), (underrunCnt - urBase) > 0, 1);
      checkOutput($sformatf("v%0d_underrun_hold", idx), holdErr - holdBase, 0);
    end
    play = 1'b0;
    step();
  endtask

  initial begin
    logic [DW-1:0] loopExp[6];
    int qBase, doneBase, aBase, busyBase, rdBase;
    bit found;
    logic [DW-1:0] preSample;

    vecs[0] = '{startA: 100, endA: 102, latency: 2,  expCount: 3, expFirst: 100, expDone: 1, expUnderrun: 0};
    vecs[1] = '{startA: 300, endA: 300, latency: 2,  expCount: 1, expFirst: 300, expDone: 1, expUnderrun: 0};
    vecs[2] = '{startA: 50,  endA: 49,  latency: 2,  expCount: 0, expFirst: 0,   expDone: 0, expUnderrun: 0};
    vecs[3] = '{startA: 20,  endA: 23,  latency: 12, expCount: 4, expFirst: 20,  expDone: 1, expUnderrun: 1};
    loopExp = '{16'd5, 16'd6, 16'd5, 16'd6, 16'd5, 16'd6};

    step();
    step();
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_sample_out", sample_out, 0);
    checkOutput("rst_sample_valid", sample_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_underrun", underrun, 0);
    Reset_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

    // looped clip 5..6
    memLatency = 2;
    qBase    = validQ.size();
    doneBase = doneCnt;
    aBase    = addrQ.size();
    Start_Addr = 5;
    End_Addr   = 6;
    loop       = 1'b1;
    play       = 1'b1;
    for (int c = 0; c < 400 && validQ.size() - qBase < 6; c++) step();
    play = 1'b0;
    loop = 1'b0;
    checkOutput("loop_count_ge6", validQ.size() - qBase >= 6, 1);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("loop_sample%0d", k),
                  (qBase + k < validQ.size()) ? longint'(validQ[qBase + k]) : -1, loopExp[k]);
    end
    checkOutput("loop_done", doneCnt - doneBase, 0);
    checkOutput("loop_addr_wrap", (addrQ.size() - aBase >= 3) ? longint'(addrQ[aBase + 2]) : -1, 5);
    step();
    step();
    checkOutput("loop_stop_busy", busy, 0);
    checkOutput("loop_stop_sample", sample_out, 0);

    // abort mid-FETCH with mem_ack in the same cycle
    qBase    = validQ.size();
    doneBase = doneCnt;
    Start_Addr = 1000;
    End_Addr   = 1010;
    play       = 1'b1;
    found      = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (mem_ack === 1'b1 && mem_addr == 1000) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_ack_seen", found, 1);
    Audio_Reset = 1'b1;
    Start_Addr  = 200;
    End_Addr    = 200;
    @(posedge Clk);
    #1;
    checkOutput("abort_mem_rd", mem_rd, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_sample_out", sample_out, 0);
    checkOutput("abort_sample_valid", sample_valid, 0);
    checkOutput("abort_done", done, 0);
    Audio_Reset = 1'b0;
    for (int c = 0; c < 300 && doneCnt == doneBase; c++) step();
    step();
    checkOutput("abort_next_count", validQ.size() - qBase, 1);
    checkOutput("abort_next_sample", (validQ.size() > qBase) ? longint'(validQ[qBase]) : -1, 200);
    checkOutput("abort_next_done", doneCnt - doneBase, 1);
    play = 1'b0;
    step();
    step();

    // asynchronous reset while a fetch is outstanding
    qBase      = validQ.size();
    Start_Addr = 400;
    End_Addr   = 410;
    play       = 1'b1;
    found      = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (validQ.size() > qBase && mem_rd === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("arst_fetch_seen", found, 1);
    preSample = sample_out;
    checkOutput("arst_pre_sample", preSample, 400);
    #1;
    Reset_n = 1'b0;
    #1;
    checkOutput("arst_mem_rd", mem_rd, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_sample_out", sample_out, 0);
    play = 1'b0;
    step();
    step();
    Reset_n = 1'b1;
    busyBase = busyCnt;
    rdBase   = rdCnt;
    for (int c = 0; c < 20; c++) step();
    checkOutput("arst_idle_busy", busyCnt - busyBase, 0);
    checkOutput("arst_idle_rd", rdCnt - rdBase, 0);
    qBase    = validQ.size();
    doneBase = doneCnt;
    Start_Addr = 7;
    End_Addr   = 7;
    play       = 1'b1;
    for (int c = 0; c < 300 && doneCnt == doneBase; c++) step();
    step();
    checkOutput("arst_replay_sample", (validQ.size() > qBase) ? longint'(validQ[qBase]) : -1, 7);
    checkOutput("arst_replay_done", doneCnt - doneBase, 1);
    play = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfx_player.md
Name: sfx_player

Overview:
- Playback engine directly downstream of the sound-effect selector.
- Consumes the selector's Start_Addr/End_Addr/play/loop/Audio_Reset, fetches 16-bit PCM samples from the audio memory port and emits one sample per sample-rate tick to the codec serializer.
- Handles one-shot and looped clips, abort on selection change, and re-arm after a one-shot clip finishes.

Parameters:
- ADDR_W, 23, sample address width.
- DATA_W, 16, sample width.
- CLK_HZ, 50000000, system clock frequency.
- SAMPLE_HZ, 8000, output sample rate; DIV = CLK_HZ/SAMPLE_HZ, integer.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  reset; one clock, asynchronous, active-low.
- play  in  1  selector requests playback.
- loop  in  1  clip repeats from Start_Addr after End_Addr.
- Audio_Reset  in  1  selection changed; abort current clip.
- Start_Addr  in  ADDR_W  first sample address, inclusive.
- End_Addr  in  ADDR_W  last sample address, inclusive.
- mem_rd  out  1  read request; held until mem_ack.
- mem_addr  out  ADDR_W  read address; stable while mem_rd=1.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  sample data.
- sample_out  out  DATA_W  current output sample, held between ticks.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a one-shot clip completes.
- underrun  out  1  one-cycle pulse when a tick arrives in FETCH.

Behaviour:
- Reset values: all outputs 0; state IDLE; armed=1; tick counter 0; cur, s_addr, e_addr, lp, buf all 0.
- Tick: free-running counter 0..DIV-1; tick=1 in the cycle the counter equals DIV-1. Not restarted on clip start, so first-sample latency is 1 to DIV cycles after data arrives.
- armed:
  - Cleared by the done pulse.
  - Set in any cycle where play=0 or Audio_Reset=1.
  - Prevents a held play from retriggering a finished one-shot clip.
- IDLE:
  - Start condition: play=1, Audio_Reset=0, armed=1, End_Addr>=Start_Addr.
  - On start, latch s_addr<=Start_Addr, e_addr<=End_Addr, lp<=loop, cur<=Start_Addr; go FETCH.
  - If End_Addr<Start_Addr: stay IDLE, no memory access, no done.
- FETCH:
  - mem_rd=1, mem_addr=cur.
  - On mem_ack: buf<=mem_rdata, mem_rd drops the next cycle, go WAIT_TICK.
  - A tick in FETCH pulses underrun; no sample is emitted and the previous sample_out is held.
- WAIT_TICK: on tick, sample_out<=buf and sample_valid pulses in the following cycle. Then:
  - cur!=e_addr: cur<=cur+1, go FETCH.
  - cur==e_addr and lp=1: cur<=s_addr, go FETCH.
  - cur==e_addr and lp=0: done pulses, go IDLE; sample_out<=0 one cycle later.
- Abort: Audio_Reset=1, or play=0 while not in IDLE.
  - Next state IDLE, mem_rd=0 next cycle, sample_out<=0, no done, no sample_valid.
  - Audio_Reset has priority over mem_ack and tick in the same cycle.
  - A mem_ack arriving after an abort is ignored.
- Fixed latched values: loop/Start_Addr/End_Addr changes mid-clip are ignored; the selector always signals a new clip with Audio_Reset.
- mem_ack while mem_rd=0 is ignored.
- cur increments without wrap; End_Addr bounds it, so 2^ADDR_W-1 is never exceeded.
- Asynchronous reset mid-transfer drops mem_rd immediately; the memory controller tolerates an abandoned request.

Decomposition:
- Package audio_pkg:
  - ADDR_W and DATA_W constants.
  - state typedef enum {IDLE, FETCH, WAIT_TICK}.
  - Silence value 16'h0000.
- One sub-module, sample_tick_gen:
  - Parameters CLK_HZ, SAMPLE_HZ.
  - Ports Clk, Reset_n, tick.
  - Shared with the codec serializer.

Test Plan (bench uses CLK_HZ=80, SAMPLE_HZ=10, DIV=8; memory model acks 2 cycles after mem_rd, data = address[15:0]):
- One-shot clip:
  - Stimulus: Start=100, End=102, play=1, loop=0.
  - Response: sample_valid ×3 with sample_out 100, 101, 102 on consecutive ticks, then done ×1, busy=0, sample_out=0.
  - With play still held for 40 more cycles: no further mem_rd.
- Loop:
  - Stimulus: Start=5, End=6, loop=1, play held for 6 ticks.
  - Response: sample_out sequence 5, 6, 5, 6, 5, 6; no done; mem_addr wraps 6→5.
- Abort:
  - Stimulus: Audio_Reset pulse mid-FETCH of address 1000, with mem_ack in the same cycle.
  - Response: next cycle mem_rd=0, state IDLE, sample_out=0, no sample_valid, no done.
  - Then Start=200, End=200: a single sample 200 plays, then done.
- Bad range:
  - Stimulus: Start=50, End=49, play=1.
  - Response: busy stays 0; mem_rd never asserts; done never pulses.
- Underrun:
  - Stimulus: memory latency set to 12 cycles.
  - Response: underrun pulses; sample_out holds its previous value; every sample eventually emits in order.
- Reset:
  - Stimulus: Reset_n low asynchronously while mem_rd=1.
  - Response: mem_rd, busy, sample_out all 0 with no clock edge; after release, idle until play is asserted.
